// File: rtl/xtea_pkg.sv
// XTEA shared definitions: key-schedule constant, FSM and mode encodings, mixing function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xtea_pkg;

   localparam logic [31:0] XTEA_DELTA = 32'h9E3779B9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      ENC = 1'b0,
      DEC = 1'b1
   } mode_t;

   // XTEA nonlinear mix: ((v<<4) ^ (v>>5)) + v, logical shifts, mod 2^32.
   function automatic logic [31:0] mix(input logic [31:0] v);
      return ((v << 4) ^ (v >> 5)) + v;
   endfunction

endpackage

// File: rtl/xtea_round.sv
// One full XTEA cycle (two Feistel half-rounds) for encryption or decryption.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module xtea_round
   import xtea_pkg::*;
#(
   parameter logic [31:0] DELTA = XTEA_DELTA
) (
   input  logic         mode_i,
   input  logic [31:0]  v0_i,
   input  logic [31:0]  v1_i,
   input  logic [31:0]  sum_i,
   input  logic [127:0] key_i,
   output logic [31:0]  v0_o,
   output logic [31:0]  v1_o,
   output logic [31:0]  sum_o
);

   // Key word k[idx]; key_i is packed {k3, k2, k1, k0}.
   function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
      return k[{idx, 5'b00000} +: 32];
   endfunction

   // Second half-round always uses the updated sum and the freshly updated word.
   always_comb begin
      v0_o  = v0_i;
      v1_o  = v1_i;
      sum_o = sum_i;
      if (mode_i == ENC) begin
         v0_o  = v0_i + (mix(v1_i) ^ (sum_i + key_word(key_i, sum_i[1:0])));
         sum_o = sum_i + DELTA;
         v1_o  = v1_i + (mix(v0_o) ^ (sum_o + key_word(key_i, sum_o[12:11])));
      end else begin
         v1_o  = v1_i - (mix(v0_i) ^ (sum_i + key_word(key_i, sum_i[12:11])));
         sum_o = sum_i - DELTA;
         v0_o  = v0_i - (mix(v1_o) ^ (sum_o + key_word(key_i, sum_o[1:0])));
      end
   end

endmodule

// File: rtl/xtea_core.sv
// Iterative XTEA engine: one full cycle per clock, separate enc/dec result registers and flags.
// Latency: start sampled at edge T gives done and result after edge T+NUM_ROUNDS.
// Backpressure: starts are only taken in IDLE; requests while busy are dropped, not queued.
module xtea_core
   import xtea_pkg::*;
#(
   parameter int          NUM_ROUNDS = 32,
   parameter logic [31:0] DELTA      = XTEA_DELTA
) (
   input  logic        clk,
   input  logic        wb_rst_i,
   input  logic        start_enc,
   input  logic        start_dec,
   input  logic [31:0] rega,
   input  logic [31:0] regb,
   input  logic [31:0] key0,
   input  logic [31:0] key1,
   input  logic [31:0] key2,
   input  logic [31:0] key3,
   output logic [31:0] result_ve0,
   output logic [31:0] result_ve1,
   output logic [31:0] result_vd0,
   output logic [31:0] result_vd1,
   output logic        done_enc,
   output logic        done_dec,
   output logic        busy
);

   // Decryption starts from the sum reached after a full encryption.
   localparam logic [63:0] SUM_FULL = 64'(DELTA) * 64'(NUM_ROUNDS);
   localparam logic [31:0] SUM_DEC  = SUM_FULL[31:0];
   localparam logic [6:0]  LAST_CNT = 7'(NUM_ROUNDS - 1);

   state_t       state_q, state_d;
   mode_t        mode_q, mode_d;
   logic [6:0]   cnt_q, cnt_d;
   logic [31:0]  v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
   logic [127:0] key_q, key_d;
   logic [31:0]  ve0_q, ve0_d, ve1_q, ve1_d, vd0_q, vd0_d, vd1_q, vd1_d;
   logic         done_enc_q, done_enc_d, done_dec_q, done_dec_d;
   logic [31:0]  rnd_v0, rnd_v1, rnd_sum;

   xtea_round #(.DELTA(DELTA)) u_round (
      .mode_i (mode_q),
      .v0_i   (v0_q),
      .v1_i   (v1_q),
      .sum_i  (sum_q),
      .key_i  (key_q),
      .v0_o   (rnd_v0),
      .v1_o   (rnd_v1),
      .sum_o  (rnd_sum)
   );

   // Next-state: latch operands on start, iterate in RUN, commit result on the final cycle.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      v0_d       = v0_q;
      v1_d       = v1_q;
      sum_d      = sum_q;
      key_d      = key_q;
      ve0_d      = ve0_q;
      ve1_d      = ve1_q;
      vd0_d      = vd0_q;
      vd1_d      = vd1_q;
      done_enc_d = done_enc_q;
      done_dec_d = done_dec_q;
      case (state_q)
         IDLE: begin
            if (start_enc) begin
               v0_d       = rega;
               v1_d       = regb;
               key_d      = {key3, key2, key1, key0};
               mode_d     = ENC;
               sum_d      = '0;
               cnt_d      = '0;
               done_enc_d = 1'b0;
               state_d    = RUN;
            end else if (start_dec) begin
               v0_d       = rega;
               v1_d       = regb;
               key_d      = {key3, key2, key1, key0};
               mode_d     = DEC;
               sum_d      = SUM_DEC;
               cnt_d      = '0;
               done_dec_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            v0_d  = rnd_v0;
            v1_d  = rnd_v1;
            sum_d = rnd_sum;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (mode_q == ENC) begin
                  ve0_d      = rnd_v0;
                  ve1_d      = rnd_v1;
                  done_enc_d = 1'b1;
               end else begin
                  vd0_d      = rnd_v0;
                  vd1_d      = rnd_v1;
                  done_dec_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any run without touching results beyond clearing them.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         mode_q     <= ENC;
         cnt_q      <= '0;
         v0_q       <= '0;
         v1_q       <= '0;
         sum_q      <= '0;
         key_q      <= '0;
         ve0_q      <= '0;
         ve1_q      <= '0;
         vd0_q      <= '0;
         vd1_q      <= '0;
         done_enc_q <= 1'b0;
         done_dec_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         sum_q      <= sum_d;
         key_q      <= key_d;
         ve0_q      <= ve0_d;
         ve1_q      <= ve1_d;
         vd0_q      <= vd0_d;
         vd1_q      <= vd1_d;
         done_enc_q <= done_enc_d;
         done_dec_q <= done_dec_d;
      end
   end

   assign result_ve0 = ve0_q;
   assign result_ve1 = ve1_q;
   assign result_vd0 = vd0_q;
   assign result_vd1 = vd1_q;
   assign done_enc   = done_enc_q;
   assign done_dec   = done_dec_q;
   assign busy       = (state_q == RUN);

endmodule

// File: doc/xtea_core.md
Name: xtea_core

Overview:
- Iterative XTEA cipher engine that sits directly downstream of the accelerator register block.
- Consumes the 64-bit data block (rega/regb) and the 128-bit key (key0..key3) from that block.
- Returns the encrypted result (result_ve0/1), the decrypted result (result_vd0/1) and the done_enc/done_dec status flags.
- One shared round datapath; encryption and decryption have independent result registers and flags.

Parameters:
NUM_ROUNDS, 32, XTEA cycles per operation (one full cycle = two Feistel half-rounds); legal range 1..64
DELTA, 32'h9E3779B9, XTEA key-schedule constant

Ports:
clk  input  1  system clock, all state on rising edge
wb_rst_i  input  1  asynchronous, active-high reset
start_enc  input  1  single-cycle request to encrypt current inputs
start_dec  input  1  single-cycle request to decrypt current inputs
rega  input  32  data word v0
regb  input  32  data word v1
key0  input  32  key word k[0]
key1  input  32  key word k[1]
key2  input  32  key word k[2]
key3  input  32  key word k[3]
result_ve0  output  32  encryption result v0
result_ve1  output  32  encryption result v1
result_vd0  output  32  decryption result v0
result_vd1  output  32  decryption result v1
done_enc  output  1  level: result_ve valid for the last accepted encryption
done_dec  output  1  level: result_vd valid for the last accepted decryption
busy  output  1  high while an operation is running

Behaviour:
- Reset: all result outputs 0, done_enc=0, done_dec=0, busy=0, FSM=IDLE, round counter=0, internal v0/v1/sum/key/mode registers 0. Reset asserted mid-operation aborts the operation with no partial result written.
- FSM states:
  - IDLE: start_enc=1 -> latch rega, regb and key0..3; mode=ENC; sum=0; done_enc<=0; go to RUN.
  - Otherwise start_dec=1 -> same latch; mode=DEC; sum=DELTA*NUM_ROUNDS mod 2^32; done_dec<=0; go to RUN.
  - Both starts high in the same cycle: encryption wins; start_dec is dropped and not queued.
  - RUN: each clock performs one full XTEA cycle and increments the counter.
  - RUN, on the edge that performs cycle NUM_ROUNDS: write the final v0/v1 into result_ve* (ENC) or result_vd* (DEC); set the matching done flag; counter<=0; go to IDLE.
  - start_enc/start_dec while in RUN are ignored entirely; inputs changing during RUN have no effect because operands are latched.
- Latency: with the start sampled at edge T, done and the result are visible after edge T+NUM_ROUNDS. busy=1 from T+1 through T+NUM_ROUNDS-1 and is low once done rises. Back-to-back starts are accepted the cycle done rises (FSM is IDLE).
- ENC cycle, all arithmetic mod 2^32, >> logical:
  - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum+k[sum[1:0]])
  - sum += DELTA
  - v1 += (((v0'<<4)^(v0'>>5))+v0') ^ (sum'+k[sum'[12:11]]), using the updated v0 and sum
- DEC cycle:
  - v1 -= (((v0<<4)^(v0>>5))+v0) ^ (sum+k[sum[12:11]])
  - sum -= DELTA
  - v0 -= (((v1'<<4)^(v1'>>5))+v1') ^ (sum'+k[sum'[1:0]])
- Key index mapping: k[0]=key0 … k[3]=key3.
- The other operation's result and done flag are untouched by a run: an encryption never clears done_dec or result_vd*, and vice versa.
- Results hold their value until overwritten by the next completion of the same mode.

Decomposition:
- xtea_pkg:
  - XTEA_DELTA constant
  - state enum {IDLE, RUN}
  - mode enum {ENC, DEC}
  - function mix(v) = ((v<<4)^(v>>5))+v
- Sub-module xtea_round: purely combinational single full cycle.
  - Inputs: mode, v0, v1, sum, 128-bit key.
  - Outputs: next v0, v1, sum.
- xtea_core holds the FSM, counter, operand latches and result registers.

Test Plan:
1. Reset, then start_enc with rega=0, regb=0, key=0 -> after 32 edges done_enc=1, result_ve0=32'hDEE9D4D8, result_ve1=32'hF7131ED9; done_dec stays 0.
2. rega=41424344, regb=45464748, key0..3=00010203/04050607/08090A0B/0C0D0E0F, start_enc -> result_ve=497DF3D0/72612CB5. Then load those into rega/regb, start_dec -> result_vd=41424344/45464748; result_ve and done_enc unchanged.
3. start_enc and start_dec pulsed in the same cycle -> only done_enc rises after 32 cycles; done_dec stays low; busy low at done.
4. start_dec and changes to rega/key issued while busy -> ignored; result equals the value from the operands latched at start; no second operation runs.
5. Assert wb_rst_i at round 10 of an encryption -> all outputs 0 immediately; FSM IDLE; a fresh start_enc gives the correct full result.
6. Random rega/regb/key, 200 iterations of encrypt then decrypt-of-result, checked against a C model -> result_vd equals the original input every time; done flags toggle per the latency rule.
